// File: rtl/bank_load_sequencer_pkg.sv
// Shared types and default parameters for the bank load sequencer.
// Imported by the interface, the button synchronizer and the sequencer top.
package bank_seq_pkg;

  typedef enum logic {
    ENTER = 1'b0,
    SHOW  = 1'b1
  } seq_state_t;

  localparam int DEF_NUM_BANKS   = 3;
  localparam int DEF_SYNC_STAGES = 2;

endpackage : bank_seq_pkg

// File: rtl/bank_load_sequencer_if.sv
// Button inputs and strobe/status outputs of the bank load sequencer.
// slave = sequencer side, master = button/board side.
interface bank_load_sequencer_if
  import bank_seq_pkg::*;
#(
  parameter int NUM_BANKS = DEF_NUM_BANKS
);

  localparam int SW = $clog2(NUM_BANKS + 1);

  logic                 btn_next;
  logic                 btn_back;
  logic                 btn_clr;
  logic [NUM_BANKS-1:0] load_en;
  logic                 bank_clr;
  logic [SW-1:0]        stage;
  logic                 done;
  logic                 showing;

  modport slave (
    input  btn_next, btn_back, btn_clr,
    output load_en, bank_clr, stage, done, showing
  );

  modport master (
    output btn_next, btn_back, btn_clr,
    input  load_en, bank_clr, stage, done, showing
  );

endinterface : bank_load_sequencer_if

// File: rtl/bank_load_sequencer_btn_edge_sync.sv
// Synchronizes one asynchronous button and emits a one-cycle pulse on its rising edge.
// Pulse is combinational from flops: high for the cycle after SYNC_STAGES edges sample the input high.
module btn_edge_sync
  import bank_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : btn_edge_sync

// File: rtl/bank_load_sequencer.sv
// Turns next/back/clear buttons into one-hot bank load strobes and a shared clear strobe.
// All outputs registered; strobe appears one cycle after the synchronized button edge.
module bank_load_sequencer
  import bank_seq_pkg::*;
#(
  parameter int NUM_BANKS   = DEF_NUM_BANKS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic           clk,
  input  logic           reset,
  bank_load_sequencer_if.slave bus
);

  localparam int SW = $clog2(NUM_BANKS + 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_BANKS - 1);
  localparam logic [SW-1:0] SHOW_STAGE = SW'(NUM_BANKS);

  logic next_ev, back_ev, clr_ev;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_next (
    .clk(clk), .reset(reset), .raw(bus.btn_next), .pulse(next_ev)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_back (
    .clk(clk), .reset(reset), .raw(bus.btn_back), .pulse(back_ev)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk(clk), .reset(reset), .raw(bus.btn_clr), .pulse(clr_ev)
  );

  seq_state_t           state_q, state_d;
  logic [SW-1:0]        stage_q, stage_d;
  logic [NUM_BANKS-1:0] load_en_q, load_en_d;
  logic                 bank_clr_q, bank_clr_d;
  logic                 done_q, done_d;
  logic                 showing_q, showing_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ENTER;
      stage_q    <= '0;
      load_en_q  <= '0;
      bank_clr_q <= 1'b0;
      done_q     <= 1'b0;
      showing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      load_en_q  <= load_en_d;
      bank_clr_q <= bank_clr_d;
      done_q     <= done_d;
      showing_q  <= showing_d;
    end
  end

  // Clear overrides everything; next beats back when both fire in one cycle.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    load_en_d  = '0;
    bank_clr_d = 1'b0;
    done_d     = 1'b0;

    if (clr_ev) begin
      state_d    = ENTER;
      stage_d    = '0;
      bank_clr_d = 1'b1;
    end else begin
      case (state_q)
        ENTER: begin
          if (next_ev) begin
            load_en_d = NUM_BANKS'(1) << stage_q;
            if (stage_q == LAST_STAGE) begin
              state_d = SHOW;
              stage_d = SHOW_STAGE;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else if (back_ev && (stage_q != '0)) begin
            stage_d = stage_q - SW'(1);
          end
        end
        SHOW: begin
          if (next_ev) begin
            state_d    = ENTER;
            stage_d    = '0;
            bank_clr_d = 1'b1;
          end else if (back_ev) begin
            state_d = ENTER;
            stage_d = LAST_STAGE;
          end
        end
        default: begin
          state_d = ENTER;
          stage_d = '0;
        end
      endcase
    end

    showing_d = (state_d == SHOW);
  end

  assign bus.load_en  = load_en_q;
  assign bus.bank_clr = bank_clr_q;
  assign bus.stage    = stage_q;
  assign bus.done     = done_q;
  assign bus.showing  = showing_q;

endmodule : bank_load_sequencer

// File: tb/tb_bank_load_sequencer.sv
// Directed bench for bank_load_sequencer with NUM_BANKS=3, SYNC_STAGES=2.
module tb_bank_load_sequencer;

  localparam int NB = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bank_load_sequencer_if #(.NUM_BANKS(NB)) bus ();

  bank_load_sequencer #(.NUM_BANKS(NB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Raise the given buttons, then stop just after the edge that registers the strobe.
  task automatic drive(input logic n, input logic b, input logic c);
    @(negedge clk);
    bus.btn_next = n; bus.btn_back = b; bus.btn_clr = c;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    @(negedge clk);
    bus.btn_next = 1'b0; bus.btn_back = 1'b0; bus.btn_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic n, input logic b, input logic c);
    drive(n, b, c);
    release_btns();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.btn_next = 1'b0; bus.btn_back = 1'b0; bus.btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.stage !== 2'd0) begin n_err++; $display("FAIL rst_stage got=%0d want=0", bus.stage); end
    n_cmp++; if (bus.load_en !== 3'b000) begin n_err++; $display("FAIL rst_load got=%b want=000", bus.load_en); end
    n_cmp++; if ({bus.bank_clr, bus.done, bus.showing} !== 3'b000) begin n_err++;
      $display("FAIL rst_flags got=%b want=000", {bus.bank_clr, bus.done, bus.showing}); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_load_sequence();
    logic [2:0] exp_load;
    for (int i = 0; i < NB; i++) begin
      exp_load = 3'b001 << i;
      drive(1'b1, 1'b0, 1'b0);
      n_cmp++; if (bus.load_en !== exp_load) begin n_err++; $display("FAIL seq_load%0d got=%b want=%b", i, bus.load_en, exp_load); end
      n_cmp++; if (bus.stage !== 2'(i + 1)) begin n_err++; $display("FAIL seq_stage%0d got=%0d want=%0d", i, bus.stage, i + 1); end
      n_cmp++; if (bus.done !== (i == NB - 1)) begin n_err++; $display("FAIL seq_done%0d got=%b want=%b", i, bus.done, (i == NB - 1)); end
      n_cmp++; if (bus.bank_clr !== 1'b0) begin n_err++; $display("FAIL seq_clr%0d got=%b want=0", i, bus.bank_clr); end
      release_btns();
      n_cmp++; if ({bus.load_en, bus.done} !== 4'b0000) begin n_err++;
        $display("FAIL seq_oneshot%0d got=%b want=0000", i, {bus.load_en, bus.done}); end
      n_cmp++; if (bus.showing !== (i == NB - 1)) begin n_err++; $display("FAIL seq_show%0d got=%b want=%b", i, bus.showing, (i == NB - 1)); end
    end
  endtask

  task automatic test_show_back();
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.stage !== 2'd2) begin n_err++; $display("FAIL showback_stage got=%0d want=2", bus.stage); end
    n_cmp++; if ({bus.load_en, bus.bank_clr, bus.showing} !== 5'b00000) begin n_err++;
      $display("FAIL showback_strobe got=%b want=00000", {bus.load_en, bus.bank_clr, bus.showing}); end
    release_btns();
  endtask

  task automatic test_back();
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.stage !== 2'd1) begin n_err++; $display("FAIL back_stage1 got=%0d want=1", bus.stage); end
    n_cmp++; if (bus.load_en !== 3'b000) begin n_err++; $display("FAIL back_load got=%b want=000", bus.load_en); end
    release_btns();
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.stage !== 2'd0) begin n_err++; $display("FAIL back_stage0 got=%0d want=0", bus.stage); end
    drive(1'b0, 1'b1, 1'b0);
    n_cmp++; if (bus.stage !== 2'd0) begin n_err++; $display("FAIL back_floor got=%0d want=0", bus.stage); end
    n_cmp++; if ({bus.load_en, bus.bank_clr} !== 4'b0000) begin n_err++;
      $display("FAIL back_floor_strobe got=%b want=0000", {bus.load_en, bus.bank_clr}); end
    release_btns();
  endtask

  task automatic test_show_next();
    repeat (NB) press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.showing !== 1'b1) begin n_err++; $display("FAIL shownext_pre got=%b want=1", bus.showing); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.bank_clr !== 1'b1) begin n_err++; $display("FAIL shownext_clr got=%b want=1", bus.bank_clr); end
    n_cmp++; if (bus.load_en !== 3'b000) begin n_err++; $display("FAIL shownext_load got=%b want=000", bus.load_en); end
    n_cmp++; if ({bus.stage, bus.showing} !== 3'b000) begin n_err++;
      $display("FAIL shownext_state got=%b want=000", {bus.stage, bus.showing}); end
    @(posedge clk); #1;
    n_cmp++; if (bus.bank_clr !== 1'b0) begin n_err++; $display("FAIL shownext_oneshot got=%b want=0", bus.bank_clr); end
    release_btns();
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.load_en !== 3'b010) begin n_err++; $display("FAIL simul_load got=%b want=010", bus.load_en); end
    n_cmp++; if (bus.stage !== 2'd2) begin n_err++; $display("FAIL simul_stage got=%0d want=2", bus.stage); end
    release_btns();
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.bank_clr !== 1'b1) begin n_err++; $display("FAIL clrnext_clr got=%b want=1", bus.bank_clr); end
    n_cmp++; if (bus.load_en !== 3'b000) begin n_err++; $display("FAIL clrnext_load got=%b want=000", bus.load_en); end
    n_cmp++; if (bus.stage !== 2'd0) begin n_err++; $display("FAIL clrnext_stage got=%0d want=0", bus.stage); end
    release_btns();
  endtask

  task automatic test_held();
    int pulses = 0;
    int first  = 0;
    @(negedge clk);
    bus.btn_next = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (bus.load_en != 3'b000) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    n_cmp++; if (pulses !== 1) begin n_err++; $display("FAIL held_pulses got=%0d want=1", pulses); end
    n_cmp++; if (first !== 3) begin n_err++; $display("FAIL held_latency got=%0d want=3", first); end
    release_btns();
    n_cmp++; if (bus.stage !== 2'd1) begin n_err++; $display("FAIL held_stage got=%0d want=1", bus.stage); end
  endtask

  task automatic test_reset_mid();
    press(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.stage !== 2'd2) begin n_err++; $display("FAIL midrst_pre got=%0d want=2", bus.stage); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.stage !== 2'd0) begin n_err++; $display("FAIL midrst_async got=%0d want=0", bus.stage); end
    n_cmp++; if ({bus.load_en, bus.bank_clr, bus.done, bus.showing} !== 6'b000000) begin n_err++;
      $display("FAIL midrst_flags got=%b want=000000", {bus.load_en, bus.bank_clr, bus.done, bus.showing}); end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_cmp++; if ({bus.stage, bus.showing} !== 3'b000) begin n_err++;
      $display("FAIL midrst_after got=%b want=000", {bus.stage, bus.showing}); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.load_en !== 3'b001) begin n_err++; $display("FAIL midrst_enter got=%b want=001", bus.load_en); end
    release_btns();
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_show_back();
    test_back();
    test_show_next();
    test_simultaneous();
    test_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bank_load_sequencer
